btnio: RTL and testbench



---
 rtl/btnio.sv | 129 ++++++++++++
 tb/tb_btnio.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btnio.sv
// btnio: read-side CPU I/O port for raw push-buttons and switches.
// Each input passes through a two-flop synchroniser and a per-bit debounce
// counter. Rising edges of the debounced level are latched as events.
// The CPU reads either the debounced level or the latched events, which are
// cleared by reading them.
//
// Optional feature (macro BTN_IRQ_EN): when defined, irq is a registered
// "event pending" flag. When undefined, irq is tied low and no irq logic
// is built.
//
// Bus protocol: read is a single-cycle strobe qualified by id. There is no
// ready/backpressure. dout carries the selected data the cycle after the
// strobe and is zero in every other cycle, so it can be OR-muxed with other
// read ports.
module btnio #(
  parameter int          NBTN        = 8,
  parameter int          DB_TICKS    = 1000000,
  parameter logic [15:0] READ_BTNS   = 16'h002B,
  parameter logic [15:0] READ_EVENTS = 16'h002C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            read,
  input  logic [15:0]     id,
  input  logic [NBTN-1:0] btns,
  output logic [15:0]     dout,
  output logic            irq
);

  localparam int            CW       = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_stable;
  logic [NBTN-1:0] r_event;
  logic [CW-1:0]   r_cnt [NBTN];
  logic [15:0]     r_dout;

  logic [NBTN-1:0] w_stable_next;
  logic [CW-1:0]   w_cnt_next [NBTN];
  logic [NBTN-1:0] w_rise;
  logic [NBTN-1:0] w_event_next;
  logic            w_btn_rd;
  logic            w_evt_rd;
  logic [15:0]     w_stable_ext;
  logic [15:0]     w_event_ext;
  logic [15:0]     w_rd_data;

  assign w_btn_rd = read && (id == READ_BTNS);
  assign w_evt_rd = read && (id == READ_EVENTS);

  // Debounce: count how long sync2 has disagreed with the debounced level.
  // The level only follows once the disagreement survives DB_TICKS cycles.
  always_comb begin
    w_stable_next = r_stable;
    for (int i = 0; i < NBTN; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_next[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Event latch: a fresh rising edge wins over a clearing read in the same cycle.
  assign w_rise       = w_stable_next & ~r_stable;
  assign w_event_next = (w_evt_rd ? '0 : r_event) | w_rise;

  // Read mux: zero-extend the selected register, zero when nothing is addressed.
  always_comb begin
    w_stable_ext               = '0;
    w_stable_ext[NBTN-1:0]     = r_stable;
    w_event_ext                = '0;
    w_event_ext[NBTN-1:0]      = r_event;
    w_rd_data                  = '0;
    if (w_btn_rd) begin
      w_rd_data = w_stable_ext;
    end else if (w_evt_rd) begin
      w_rd_data = w_event_ext;
    end
  end

  // State update: synchroniser, debounce counters, level, events, read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_event  <= '0;
      r_dout   <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= btns;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_next;
      r_event  <= w_event_next;
      r_dout   <= w_rd_data;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign dout = r_dout;

`ifdef BTN_IRQ_EN
  logic r_irq;

  // Interrupt tracks whether any event is pending after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_event_next;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_btnio.sv
// tb_btnio: directed vector table, hand-written corner sequences and random
// stimulus for btnio, all checked against a sliding-window reference model.
module tb_btnio;

  localparam int          NBTN   = 8;
  localparam int          DB     = 4;
  localparam logic [15:0] ID_BTN = 16'h002B;
  localparam logic [15:0] ID_EVT = 16'h002C;

  logic            clk = 1'b0;
  logic            reset;
  logic            read;
  logic [15:0]     id;
  logic [NBTN-1:0] btns;
  logic [15:0]     dout;
  logic            irq;

  btnio #(
    .NBTN        (NBTN),
    .DB_TICKS    (DB),
    .READ_BTNS   (ID_BTN),
    .READ_EVENTS (ID_EVT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .read  (read),
    .id    (id),
    .btns  (btns),
    .dout  (dout),
    .irq   (irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues filled by the model, drained after each edge
  logic [15:0] exp_q[$];
  logic        exp_irq_q[$];

  // Reference model state
  logic [NBTN-1:0] m_hist[$];   // raw samples in flight: [0] is the synchroniser output
  logic [NBTN-1:0] m_win[$];    // last DB synchroniser outputs, oldest first
  logic [NBTN-1:0] m_stable;
  logic [NBTN-1:0] m_event;

  typedef struct {
    logic            r;
    logic            rd;
    logic [15:0]     id;
    logic [NBTN-1:0] b;
    logic [15:0]     exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock edge of the behavioural model. A debounced bit flips when every
  // one of the last DB synchroniser samples disagrees with it.
  task automatic model_edge(input logic r, input logic rd, input logic [15:0] i,
                            input logic [NBTN-1:0] b);
    logic [NBTN-1:0] all_hi, all_lo, nstab, rise;
    logic [15:0]     d;
    d = '0;
    if (r) begin
      m_hist   = {NBTN'(0), NBTN'(0)};
      m_win    = {};
      for (int k = 0; k < DB; k++) m_win.push_back('0);
      m_stable = '0;
      m_event  = '0;
    end else begin
      all_hi = '1;
      all_lo = '1;
      foreach (m_win[j]) begin
        all_hi &= m_win[j];
        all_lo &= ~m_win[j];
      end
      nstab = m_stable;
      for (int k = 0; k < NBTN; k++) begin
        if (m_stable[k] ? all_lo[k] : all_hi[k]) nstab[k] = ~m_stable[k];
      end
      rise = nstab & ~m_stable;
      if (rd && i == ID_BTN)      d = 16'(m_stable);
      else if (rd && i == ID_EVT) d = 16'(m_event);
      m_event  = ((rd && i == ID_EVT) ? '0 : m_event) | rise;
      m_stable = nstab;
      m_hist.push_back(b);
      void'(m_hist.pop_front());
      m_win.push_back(m_hist[0]);
      void'(m_win.pop_front());
    end
    exp_q.push_back(d);
`ifdef BTN_IRQ_EN
    exp_irq_q.push_back(|m_event);
`else
    exp_irq_q.push_back(1'b0);
`endif
  endtask

  // Driver: apply inputs, clock once, check dout and irq against the model
  task automatic step(input logic r, input logic rd, input logic [15:0] i,
                      input logic [NBTN-1:0] b);
    reset = r;
    read  = rd;
    id    = i;
    btns  = b;
    @(posedge clk);
    model_edge(r, rd, i, b);
    #1;
    check16("dout_model", dout, exp_q.pop_front());
    check1("irq_model", irq, exp_irq_q.pop_front());
  endtask

  task automatic idle(input int n, input logic [NBTN-1:0] b);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, b);
  endtask

  logic [NBTN-1:0] cur;
  logic [15:0]     rid;
  logic            rrd, rrst;
  int              bit_idx;

  initial begin
    reset = 1'b1;
    read  = 1'b0;
    id    = '0;
    btns  = '0;

    // Reset with buttons held, settling, then off-port reads and clear-on-read
    tbl.push_back('{1'b1, 1'b1, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b1, 1'b1, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_EVT,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 16'h0000,    8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h00FF});
    tbl.push_back('{1'b0, 1'b1, 16'h002A,    8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, 16'h0000,    8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, ID_EVT,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_EVT,      8'hFF, 16'h00FF});
    tbl.push_back('{1'b0, 1'b1, ID_EVT,      8'hFF, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h00FF});
    tbl.push_back('{1'b0, 1'b1, ID_BTN,      8'hFF, 16'h00FF});

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].rd, tbl[k].id, tbl[k].b);
      check16("table", dout, tbl[k].exp);
    end

    // Release everything (falling edges make no events)
    idle(8, 8'h00);
    step(1'b0, 1'b1, ID_EVT, 8'h00);
    check16("release_no_event", dout, 16'h0000);

    // Bounce on bit 2 never reaches the debounced level
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, ID_BTN, (((c / 2) % 2) == 0) ? 8'h04 : 8'h00);
      check16("bounce_level", dout, 16'h0000);
    end
    // Final press: level changes on the fifth edge after, visible on the sixth read
    for (int k = 0; k <= 6; k++) begin
      step(1'b0, 1'b1, ID_BTN, 8'h04);
      check16("bounce_settle", dout, (k == 6) ? 16'h0004 : 16'h0000);
    end
    step(1'b0, 1'b1, ID_EVT, 8'h04);
    check16("bounce_event", dout, 16'h0004);
    step(1'b0, 1'b1, ID_EVT, 8'h04);
    check16("bounce_event_clr", dout, 16'h0000);

    // Two presses before a read collapse into one event; release makes none
    idle(8, 8'h05);
    idle(8, 8'h04);
    idle(8, 8'h05);
    step(1'b0, 1'b1, ID_EVT, 8'h05);
    check16("double_press", dout, 16'h0001);
    step(1'b0, 1'b1, ID_EVT, 8'h05);
    check16("double_press_clr", dout, 16'h0000);
    idle(8, 8'h04);
    step(1'b0, 1'b1, ID_EVT, 8'h04);
    check16("release_only", dout, 16'h0000);

    // Rising edge on bit 5 coincides with a clearing read of event bit 0
    idle(8, 8'h05);
`ifdef BTN_IRQ_EN
    check1("irq_set", irq, 1'b1);
`else
    check1("irq_off", irq, 1'b0);
`endif
    idle(5, 8'h25);
    step(1'b0, 1'b1, ID_EVT, 8'h25);
    check16("set_wins_read", dout, 16'h0001);
`ifdef BTN_IRQ_EN
    check1("irq_held", irq, 1'b1);
`endif
    step(1'b0, 1'b1, ID_EVT, 8'h25);
    check16("set_wins_next", dout, 16'h0020);
    check1("irq_clr", irq, 1'b0);
    step(1'b0, 1'b1, ID_EVT, 8'h25);
    check16("set_wins_clr", dout, 16'h0000);

    // Random stimulus with occasional resets, including mid-debounce
    cur = '0;
    step(1'b1, 1'b0, 16'h0000, cur);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        bit_idx = $urandom_range(0, NBTN - 1);
        cur[bit_idx] = ~cur[bit_idx];
      end
      rrd  = ($urandom_range(0, 1) == 1);
      rrst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0:       rid = ID_BTN;
        1:       rid = ID_EVT;
        2:       rid = 16'h002A;
        default: rid = 16'($urandom);
      endcase
      step(rrst, rrd, rid, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
